egg_input_ctrl: RTL and testbench

- Front-panel input stage that sits directly upstream of the egg timer core.
- Synchronises and debounces three raw push-buttons: start, up and down.
- Converts the start button into a single-cycle start pulse.
- Maintains the user-selected timer duration (max) with the up/down buttons; start and max drive the timer core's start and max inputs directly.
- Runs on the same 1 kHz clk as the timer core.

---
 rtl/egg_input_ctrl.sv | 177 +++++++++++++++++
 tb/tb_egg_input_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/egg_input_ctrl.sv
// Front-panel input stage for the egg timer: synchronises, debounces and edge-detects
// start/up/down and keeps the selected duration. Auto-repeat enabled by EGG_INPUT_AUTOREPEAT_EN.
module egg_input_ctrl #(
  parameter int SIZE          = 4,
  parameter int DEBOUNCE      = 20,
  parameter int MAX_INIT      = 5,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_start,
  input  logic            btn_up,
  input  logic            btn_down,
  output logic            start,
  output logic [SIZE-1:0] max,
  output logic [2:0]      btn_level
);

  localparam logic [7:0]      DEB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [SIZE-1:0] MAX_TOP  = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] MAX_BOT  = SIZE'(1);
  localparam logic [SIZE-1:0] MAX_RST  = SIZE'(MAX_INIT);

  // Elaboration-time parameter legality
  if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("egg_input_ctrl: DEBOUNCE out of range");
  end
  if (MAX_INIT < 1 || MAX_INIT > (2 ** SIZE) - 1) begin : g_bad_max_init
    $error("egg_input_ctrl: MAX_INIT out of range");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY || REPEAT_DELAY > 65535) begin : g_bad_repeat
    $error("egg_input_ctrl: REPEAT_DELAY/REPEAT_PERIOD out of range");
  end

  // Bit order everywhere: [2]=start, [1]=up, [0]=down
  logic [2:0]      raw_s;
  logic [2:0]      sync1_r;
  logic [2:0]      sync2_r;
  logic [2:0]      deb_r;
  logic [2:0]      deb_prev_r;
  logic [2:0]      rise_s;
  logic [7:0]      cnt_r [3];
  logic            start_r;
  logic            inc_r;
  logic            dec_r;
  logic            inc_step_s;
  logic            dec_step_s;
  logic [SIZE-1:0] max_r;
  logic [SIZE-1:0] max_nxt_s;

  assign raw_s  = {btn_start, btn_up, btn_down};
  assign rise_s = deb_r & ~deb_prev_r;

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= 8'd0;
      end
      deb_r <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= 8'd0;
        end else if (cnt_r[i] == DEB_LAST) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= 8'd0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 8'd1;
        end
      end
    end
  end

`ifdef EGG_INPUT_AUTOREPEAT_EN
  localparam logic [15:0] REP_FIRE   = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] REP_RELOAD = 16'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [15:0] hold_cnt_r;
  logic        hold_one_s;
  logic        hold_clr_s;
  logic        rep_s;

  // Only a lone held up or down button repeats; any edge on either restarts the hold time
  assign hold_one_s = deb_r[1] ^ deb_r[0];
  assign hold_clr_s = (|(rise_s[1:0])) | (|(deb_prev_r[1:0] & ~deb_r[1:0])) | ~hold_one_s;
  assign rep_s      = hold_one_s & ~hold_clr_s & (hold_cnt_r == REP_FIRE);

  // Shared hold counter; reloading on a repeat makes later steps REPEAT_PERIOD apart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_r <= 16'd0;
    end else if (hold_clr_s) begin
      hold_cnt_r <= 16'd0;
    end else if (rep_s) begin
      hold_cnt_r <= REP_RELOAD;
    end else begin
      hold_cnt_r <= hold_cnt_r + 16'd1;
    end
  end

  // Step requests: debounced rise plus auto-repeat
  always_comb begin
    inc_step_s = rise_s[1] | (rep_s & deb_r[1]);
    dec_step_s = rise_s[0] | (rep_s & deb_r[0]);
  end
`else
  // Step requests: one per debounced rise
  always_comb begin
    inc_step_s = rise_s[1];
    dec_step_s = rise_s[0];
  end
`endif

  // Registered single-cycle pulses and previous-level flops for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_prev_r <= 3'b000;
      start_r    <= 1'b0;
      inc_r      <= 1'b0;
      dec_r      <= 1'b0;
    end else begin
      deb_prev_r <= deb_r;
      start_r    <= rise_s[2];
      inc_r      <= inc_step_s;
      dec_r      <= dec_step_s;
    end
  end

  // Saturating duration update; simultaneous inc and dec cancel
  always_comb begin
    max_nxt_s = max_r;
    case ({inc_r, dec_r})
      2'b10: begin
        if (max_r == MAX_TOP) begin
          max_nxt_s = max_r;
        end else begin
          max_nxt_s = max_r + SIZE'(1);
        end
      end
      2'b01: begin
        if (max_r <= MAX_BOT) begin
          max_nxt_s = MAX_BOT;
        end else begin
          max_nxt_s = max_r - SIZE'(1);
        end
      end
      default: max_nxt_s = max_r;
    endcase
  end

  // Duration register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_r <= MAX_RST;
    end else begin
      max_r <= max_nxt_s;
    end
  end

  assign start     = start_r;
  assign max       = max_r;
  assign btn_level = deb_r;

endmodule

// File: tb/tb_egg_input_ctrl.sv
// Directed self-checking bench for egg_input_ctrl with DEBOUNCE=4, MAX_INIT=5, SIZE=4.
module tb_egg_input_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       start;
  logic [3:0] max_v;
  logic [2:0] btn_level;

  int checks = 0;
  int failures = 0;

  egg_input_ctrl #(
    .SIZE(4),
    .DEBOUNCE(4),
    .MAX_INIT(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start(btn_start),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .start(start),
    .max(max_v),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    int         ticks;
    int         exp_max;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] b);
    {btn_start, btn_up, btn_down} = b;
  endtask

  initial begin
    int m;
    int base;
    int steps;
    int prev;
    vec_t v;

    // Vector table: simultaneous press, 12 up presses, 16 down presses, start+down at floor
    m = 5;
    v = '{3'b011, 10, 5, 3'b011}; vecs.push_back(v);
    v = '{3'b000, 10, 5, 3'b000}; vecs.push_back(v);
    for (int i = 0; i < 12; i++) begin
      m = (m < 15) ? m + 1 : 15;
      v = '{3'b010, 10, m, 3'b010}; vecs.push_back(v);
      v = '{3'b000, 10, m, 3'b000}; vecs.push_back(v);
    end
    for (int i = 0; i < 16; i++) begin
      m = (m > 1) ? m - 1 : 1;
      v = '{3'b001, 10, m, 3'b001}; vecs.push_back(v);
      v = '{3'b000, 10, m, 3'b000}; vecs.push_back(v);
    end
    v = '{3'b101, 10, 1, 3'b101}; vecs.push_back(v);
    v = '{3'b000, 10, 1, 3'b000}; vecs.push_back(v);

    // Power-on reset
    #2 rst = 1'b0;
    #1;
    check("por start", int'(start), 0);
    check("por max", int'(max_v), 5);
    check("por level", int'(btn_level), 0);
    tick();
    tick();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_btn(vecs[i].btn);
      repeat (vecs[i].ticks) tick();
      check($sformatf("vec%0d max", i), int'(max_v), vecs[i].exp_max);
      check($sformatf("vec%0d level", i), int'(btn_level), int'(vecs[i].exp_level));
    end

    // Asynchronous reset mid-cycle with buttons low: max 1 -> 5 without a clock edge
    #3 rst = 1'b0;
    #1;
    check("async rst max", int'(max_v), 5);
    check("async rst start", int'(start), 0);
    check("async rst level", int'(btn_level), 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Reset during a debounce: held down is re-debounced from scratch, one decrement
    set_btn(3'b001);
    repeat (3) tick();
    #3 rst = 1'b0;
    #1;
    check("mid-deb rst level", int'(btn_level), 0);
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("redeb level t%0d", k), int'(btn_level[0]), (k >= 6) ? 1 : 0);
      check($sformatf("redeb max t%0d", k), int'(max_v), (k >= 8) ? 4 : 5);
    end
    set_btn(3'b000);
    repeat (10) tick();

    // Clean start press: level from edge 6, one pulse on edge 7, nothing on hold/release
    set_btn(3'b100);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("press level t%0d", k), int'(btn_level[2]), (k >= 6) ? 1 : 0);
      check($sformatf("press start t%0d", k), int'(start), (k == 7) ? 1 : 0);
    end
    set_btn(3'b000);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("release start t%0d", k), int'(start), 0);
    end
    check("release level", int'(btn_level), 0);
    check("start no max change", int'(max_v), 4);

    // Bouncing up button, then stable high: exactly one increment 8 edges later
    base = int'(max_v);
    for (int p = 0; p < 3; p++) begin
      set_btn(3'b010);
      repeat (2) begin
        tick();
        check("bounce max", int'(max_v), base);
        check("bounce level", int'(btn_level[1]), 0);
      end
      set_btn(3'b000);
      repeat (2) begin
        tick();
        check("bounce max", int'(max_v), base);
        check("bounce level", int'(btn_level[1]), 0);
      end
    end
    set_btn(3'b010);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("stable max t%0d", k), int'(max_v), (k >= 8) ? base + 1 : base);
    end
    set_btn(3'b000);
    repeat (10) tick();

    // Long hold: without auto-repeat exactly one increment
    base = int'(max_v);
    prev = base;
    steps = 0;
    set_btn(3'b010);
    for (int k = 0; k < 42; k++) begin
      if (k == 30) set_btn(3'b000);
      tick();
      if (int'(max_v) != prev) steps++;
      prev = int'(max_v);
    end
    check("hold steps", steps, 1);
    check("hold max", int'(max_v), base + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
